// File: rtl/memory_stage.sv
// Memory pipeline stage: pass-through for ALU ops, blocking request/ack handshake for LOAD/STORE
// with a bounded wait and a sticky timeout flag.
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  control_in,
  input  logic [15:0] result_in,
  input  logic [15:0] store_data_in,
  input  logic [4:0]  dest_index_in,
  input  logic        write_en_in,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        wb_write_en,
  output logic [3:0]  wb_control,
  output logic        mem_err
);

  localparam logic [3:0] OpLoad  = 4'b1100;
  localparam logic [3:0] OpStore = 4'b1110;
  localparam logic [3:0] OpNop   = 4'b0000;
  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic [4:0]  cap_dest_q;
  logic        cap_we_q;
  logic        cap_store_q;
  logic        mem_req_q, mem_we_q, mem_err_q;
  logic [15:0] mem_addr_q, mem_wdata_q, wb_data_q;
  logic [4:0]  wb_dest_q;
  logic        wb_write_en_q;
  logic [3:0]  wb_control_q;
  logic        is_mem;

  assign is_mem = (control_in == OpLoad) || (control_in == OpStore);
  assign stall  = ((state_q == StIdle) && is_mem) || (state_q == StAccess);

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_data     = wb_data_q;
  assign wb_dest     = wb_dest_q;
  assign wb_write_en = wb_write_en_q;
  assign wb_control  = wb_control_q;
  assign mem_err     = mem_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      wait_cnt_q    <= 8'd0;
      cap_dest_q    <= 5'd0;
      cap_we_q      <= 1'b0;
      cap_store_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_err_q     <= 1'b0;
      mem_addr_q    <= 16'd0;
      mem_wdata_q   <= 16'd0;
      wb_data_q     <= 16'd0;
      wb_dest_q     <= 5'd0;
      wb_write_en_q <= 1'b0;
      wb_control_q  <= OpNop;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_mem) begin
            mem_req_q     <= 1'b1;
            mem_we_q      <= (control_in == OpStore);
            mem_addr_q    <= result_in;
            mem_wdata_q   <= store_data_in;
            cap_dest_q    <= dest_index_in;
            cap_we_q      <= write_en_in;
            cap_store_q   <= (control_in == OpStore);
            wait_cnt_q    <= 8'd0;
            wb_write_en_q <= 1'b0;
            wb_control_q  <= OpNop;
            state_q       <= StAccess;
          end else begin
            wb_data_q     <= result_in;
            wb_dest_q     <= dest_index_in;
            wb_write_en_q <= write_en_in;
            wb_control_q  <= control_in;
          end
        end
        StAccess: begin
          // An ack on the final wait cycle still completes the access normally.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= StDone;
            if (cap_store_q) begin
              wb_write_en_q <= 1'b0;
              wb_control_q  <= OpStore;
            end else begin
              wb_data_q     <= mem_rdata;
              wb_dest_q     <= cap_dest_q;
              wb_write_en_q <= cap_we_q;
              wb_control_q  <= OpLoad;
            end
          end else if (wait_cnt_q == WaitLast) begin
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_err_q     <= 1'b1;
            wb_write_en_q <= 1'b0;
            wb_control_q  <= OpNop;
            state_q       <= StDone;
          end else begin
            if (wait_cnt_q != 8'hFF) begin
              wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            wb_write_en_q <= 1'b0;
            wb_control_q  <= OpNop;
          end
        end
        StDone: begin
          wb_write_en_q <= 1'b0;
          wb_control_q  <= OpNop;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: transaction-level model feeds writeback and memory-request scoreboards;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_memory_stage;

  localparam int unsigned T = 16;
  localparam logic [3:0] LOAD = 4'b1100, STORE = 4'b1110, NOP = 4'b0000, ADD = 4'b0010;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  control_in;
  logic [15:0] result_in, store_data_in, mem_rdata;
  logic [4:0]  dest_index_in;
  logic        write_en_in, mem_ack;
  logic        stall, mem_req, mem_we, wb_write_en, mem_err;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  logic [4:0]  wb_dest;
  logic [3:0]  wb_control;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .control_in(control_in), .result_in(result_in),
    .store_data_in(store_data_in), .dest_index_in(dest_index_in), .write_en_in(write_en_in),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_write_en(wb_write_en), .wb_control(wb_control), .mem_err(mem_err)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  dest;
    logic        we;
    logic [3:0]  ctrl;
  } wb_t;
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
  } mreq_t;

  wb_t   wbq[$];
  mreq_t mq[$];
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  bit    err_exp = 1'b0;
  logic        st_tr[$], req_tr[$], wen_tr[$];
  logic [3:0]  ctl_tr[$];
  logic [15:0] dat_tr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one writeback event per cycle where the DUT shows a non-bubble.
  initial begin : monitor
    wb_t   e;
    mreq_t cur;
    bit    prev_req;
    prev_req = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (wb_write_en || wb_control != NOP) begin
          if (wbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got ctrl %h we %b expected no writeback",
                     wb_control, wb_write_en);
          end else begin
            e = wbq.pop_front();
            chk("wb_control", 32'(wb_control), 32'(e.ctrl));
            chk("wb_write_en", 32'(wb_write_en), 32'(e.we));
            if (e.ctrl != STORE) begin
              chk("wb_data", 32'(wb_data), 32'(e.data));
              chk("wb_dest", 32'(wb_dest), 32'(e.dest));
            end
          end
        end
        if (mem_req) begin
          if (!prev_req) begin
            if (mq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL mem_req_unexpected: got addr %h expected no request", mem_addr);
            end else begin
              cur = mq.pop_front();
            end
          end
          chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
          chk("mem_we", 32'(mem_we), 32'(cur.we));
        end else begin
          chk("mem_we_no_req", 32'(mem_we), 32'd0);
        end
        prev_req = mem_req;
      end
    end
  end

  // Issue one instruction; d = ack delay in ACCESS cycles (d >= T means never ack).
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] wd,
                        input logic [4:0] dst, input logic we, input int d,
                        input logic [15:0] rd, input bit spur);
    bit   is_mem;
    int   c;
    int   acc_end;
    logic st;
    is_mem = (op == LOAD) || (op == STORE);
    acc_end = !is_mem ? 0 : (d < int'(T) ? d + 1 : int'(T));
    c = 0;
    if (is_mem) begin
      mq.push_back('{addr: a, wdata: wd, we: (op == STORE)});
      if (d >= int'(T)) err_exp = 1'b1;
      else if (op == LOAD) wbq.push_back('{data: rd, dest: dst, we: we, ctrl: LOAD});
      else wbq.push_back('{data: 16'd0, dest: 5'd0, we: 1'b0, ctrl: STORE});
    end else if (op != NOP || we) begin
      wbq.push_back('{data: a, dest: dst, we: we, ctrl: op});
    end
    st_tr.delete(); req_tr.delete(); wen_tr.delete(); ctl_tr.delete(); dat_tr.delete();
    forever begin
      control_in = op; result_in = a; store_data_in = wd;
      dest_index_in = dst; write_en_in = we;
      if (is_mem && c >= 1 && c <= acc_end) begin
        mem_ack = (d < int'(T)) && (c == d + 1);
        mem_rdata = mem_ack ? rd : 16'($urandom);
      end else begin
        mem_ack = spur && ($urandom_range(0, 3) == 0);
        mem_rdata = 16'($urandom);
      end
      #1;
      st = stall;
      st_tr.push_back(st); req_tr.push_back(mem_req); wen_tr.push_back(wb_write_en);
      ctl_tr.push_back(wb_control); dat_tr.push_back(wb_data);
      @(posedge clk);
      @(negedge clk);
      c++;
      if (!st) break;
      if (c > 40) begin
        checks++;
        errors++;
        $display("FAIL op_bound: got stall still high after %0d cycles expected release", c);
        break;
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    reset = 1'b1; control_in = NOP; result_in = '0; store_data_in = '0;
    dest_index_in = '0; write_en_in = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_wb_dest", 32'(wb_dest), 32'd0);
    chk("rst_wb_write_en", 32'(wb_write_en), 32'd0);
    chk("rst_wb_control", 32'(wb_control), 32'(NOP));
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    mon_en = 1'b1;

    // ADD pass-through
    run_op(ADD, 16'h1234, 16'h0, 5'd5, 1'b1, 0, 16'h0, 1'b0);
    chk("add_cycles", 32'(st_tr.size()), 32'd1);
    chk("add_stall", 32'(st_tr[0]), 32'd0);
    #1;
    chk("add_wb_data", 32'(wb_data), 32'h1234);
    chk("add_wb_dest", 32'(wb_dest), 32'd5);
    chk("add_wb_we", 32'(wb_write_en), 32'd1);

    // LOAD with immediate ack
    run_op(LOAD, 16'h0040, 16'h5555, 5'd7, 1'b1, 0, 16'hBEEF, 1'b0);
    chk("ld0_cycles", 32'(st_tr.size()), 32'd3);
    chk("ld0_stall_idle", 32'(st_tr[0]), 32'd1);
    chk("ld0_stall_access", 32'(st_tr[1]), 32'd1);
    chk("ld0_stall_done", 32'(st_tr[2]), 32'd0);
    chk("ld0_wb_data", 32'(dat_tr[2]), 32'hBEEF);
    chk("ld0_wb_we", 32'(wen_tr[2]), 32'd1);

    // STORE with three wait cycles
    run_op(STORE, 16'h0010, 16'h00AA, 5'd2, 1'b1, 3, 16'h0, 1'b0);
    chk("st3_cycles", 32'(st_tr.size()), 32'd6);
    n = 0;
    for (int i = 1; i <= 4; i++) n += int'(req_tr[i]);
    chk("st3_req_cycles", 32'(n), 32'd4);
    chk("st3_req_after_ack", 32'(req_tr[5]), 32'd0);
    chk("st3_wb_ctrl", 32'(ctl_tr[5]), 32'(STORE));
    n = 0;
    for (int i = 1; i <= 5; i++) n += int'(wen_tr[i]);
    chk("st3_wb_we", 32'(n), 32'd0);

    // LOAD followed by ADD
    run_op(LOAD, 16'h0080, 16'h0, 5'd9, 1'b1, 1, 16'hCAFE, 1'b1);
    chk("ldadd_load_ctrl", 32'(ctl_tr[3]), 32'(LOAD));
    chk("ldadd_load_data", 32'(dat_tr[3]), 32'hCAFE);
    run_op(ADD, 16'h0777, 16'h0, 5'd3, 1'b1, 0, 16'h0, 1'b0);
    chk("ldadd_bubble", 32'(ctl_tr[0]), 32'(NOP));
    chk("ldadd_data_kept", 32'(dat_tr[0]), 32'hCAFE);
    #1;
    chk("ldadd_add_ctrl", 32'(wb_control), 32'(ADD));
    chk("ldadd_add_data", 32'(wb_data), 32'h0777);
    chk("err_before_timeout", 32'(mem_err), 32'd0);

    // LOAD timeout
    run_op(LOAD, 16'h0100, 16'h0, 5'd4, 1'b1, 99, 16'h0, 1'b1);
    chk("to_cycles", 32'(st_tr.size()), 32'(T + 2));
    n = 0;
    for (int i = 0; i < st_tr.size(); i++) n += int'(req_tr[i]);
    chk("to_req_cycles", 32'(n), 32'(T));
    chk("to_req_dropped", 32'(req_tr[T + 1]), 32'd0);
    n = 0;
    for (int i = 1; i < st_tr.size(); i++) n += int'(wen_tr[i]);
    chk("to_wb_we", 32'(n), 32'd0);
    chk("to_err", 32'(mem_err), 32'd1);
    run_op(NOP, 16'h0, 16'h0, 5'd0, 1'b0, 0, 16'h0, 1'b1);
    run_op(ADD, 16'h0042, 16'h0, 5'd1, 1'b1, 0, 16'h0, 1'b1);
    chk("to_err_sticky", 32'(mem_err), 32'd1);

    // Reset during the second ACCESS cycle of a LOAD, with a competing ack
    mq.push_back('{addr: 16'h0200, wdata: 16'h0, we: 1'b0});
    control_in = LOAD; result_in = 16'h0200; store_data_in = 16'h0;
    dest_index_in = 5'd6; write_en_in = 1'b1; mem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; mem_ack = 1'b0; control_in = NOP; write_en_in = 1'b0;
    #1;
    chk("rstacc_stall", 32'(stall), 32'd0);
    chk("rstacc_req", 32'(mem_req), 32'd0);
    chk("rstacc_err", 32'(mem_err), 32'd0);
    chk("rstacc_wb_we", 32'(wb_write_en), 32'd0);
    chk("rstacc_wb_ctrl", 32'(wb_control), 32'(NOP));
    err_exp = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
    chk("rstacc_no_wb", 32'(wb_write_en), 32'd0);
    @(negedge clk);

    // Randomized mix
    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
      int sel, d;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) op = LOAD;
      else if (sel == 1) op = STORE;
      else begin
        op = 4'($urandom_range(0, 15));
        while (op == LOAD || op == STORE) op = 4'($urandom_range(0, 15));
      end
      d = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      run_op(op, 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom), d,
             16'($urandom), 1'b1);
    end

    run_op(NOP, 16'h0, 16'h0, 5'd0, 1'b0, 0, 16'h0, 1'b0);
    run_op(NOP, 16'h0, 16'h0, 5'd0, 1'b0, 0, 16'h0, 1'b0);
    chk("wb_queue_drained", 32'(wbq.size()), 32'd0);
    chk("mreq_queue_drained", 32'(mq.size()), 32'd0);
    chk("final_err", 32'(mem_err), 32'(err_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16: the maximum number of ACCESS cycles waited for mem_ack before the access is aborted (legal range 2..255).
REQ-002 The block SHALL have these ports, clock and reset first:
- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- control_in, input, 4: opcode from execute. LOAD=4'b1100, STORE=4'b1110, NOP=4'b0000; all other codes are non-memory.
- result_in, input, 16: ALU result; memory address for LOAD/STORE.
- store_data_in, input, 16: STORE write data.
- dest_index_in, input, 5: destination register index.
- write_en_in, input, 1: destination register write enable from execute.
- mem_rdata, input, 16: data-memory read data, valid with mem_ack.
- mem_ack, input, 1: data-memory completion strobe.
- stall, output, 1: upstream holds all inputs stable while high.
- mem_req, output, 1: registered memory request.
- mem_we, output, 1: registered write strobe.
- mem_addr, output, 16: registered address.
- mem_wdata, output, 16: registered write data.
- wb_data, output, 16: writeback data.
- wb_dest, output, 5: writeback register index.
- wb_write_en, output, 1: writeback enable.
- wb_control, output, 4: opcode forwarded to writeback.
- mem_err, output, 1: sticky timeout flag.
REQ-003 The block SHALL use one clock (clk) and a synchronous, active-high reset (reset).

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-005 In IDLE with a non-memory opcode, the block SHALL register the following on the next edge (1-cycle latency), and stall SHALL be 0:
- wb_data<=result_in
- wb_dest<=dest_index_in
- wb_write_en<=write_en_in
- wb_control<=control_in
REQ-006 In IDLE with LOAD or STORE:
- stall SHALL be 1 combinationally.
- On the edge, mem_req<=1, mem_addr<=result_in, mem_wdata<=store_data_in, and mem_we<=(control_in==STORE).
- The block SHALL capture dest_index_in, write_en_in and control_in, clear the wait counter, and go to ACCESS.
- The block SHALL register a writeback bubble (wb_write_en<=0, wb_control<=NOP).
REQ-007 In ACCESS:
- stall SHALL be 1, and mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable.
- Each edge without mem_ack SHALL increment the wait counter and register a writeback bubble.
REQ-008 In ACCESS with mem_ack=1 on an edge, the block SHALL deassert mem_req and mem_we and go to DONE. It SHALL register writeback as follows:
- LOAD: wb_data<=mem_rdata, wb_write_en<=captured write_en, wb_dest<=captured index, wb_control<=LOAD.
- STORE: wb_write_en<=0, wb_control<=STORE.
REQ-009 In ACCESS, if the wait counter equals TIMEOUT_CYCLES-1 and mem_ack=0, the block SHALL:
- deassert mem_req and mem_we;
- set mem_err<=1;
- register a writeback bubble;
- go to DONE.
mem_ack arriving in that same cycle SHALL take priority over the timeout.
REQ-010 In DONE, stall SHALL be 0, inputs SHALL be ignored (the held memory op is consumed), a writeback bubble SHALL be registered, and the next state SHALL be IDLE.
REQ-011 mem_ack SHALL be ignored in IDLE and DONE.
REQ-012 mem_err SHALL remain 1 until reset.
REQ-013 The wait counter SHALL be 8 bits wide and SHALL NOT wrap.
REQ-014 stall SHALL equal (state==IDLE && opcode is LOAD/STORE) || state==ACCESS.
REQ-015 Back-to-back memory ops SHALL each incur a full IDLE->ACCESS->DONE sequence, with no overlap.

Reset
REQ-016 While reset=1 on an edge, the block SHALL set:
- state<=IDLE; wait counter<=0;
- mem_req, mem_we and mem_err<=0;
- mem_addr and mem_wdata<=0;
- wb_data<=0, wb_dest<=0, wb_write_en<=0, wb_control<=NOP.
REQ-017 Reset asserted mid-ACCESS SHALL abort the access: mem_req SHALL be 0 after the edge, and no writeback SHALL occur for the aborted op.
REQ-018 Reset SHALL take priority over mem_ack and the timeout.

Verification
REQ-019 The bench SHALL cover an ADD pass-through: control_in=0010, result_in=16'h1234, dest 5, write_en 1 -> next edge wb_data=1234, wb_dest=5, wb_write_en=1, with stall=0 throughout.
REQ-020 The bench SHALL cover a LOAD with immediate ack: addr 16'h0040, mem_ack and mem_rdata=16'hBEEF in the first ACCESS cycle -> wb_data=BEEF and wb_write_en=1 after that edge; stall high for 2 cycles, then low in DONE.
REQ-021 The bench SHALL cover a STORE with 3 wait cycles: addr 16'h0010, data 16'h00AA -> mem_req/mem_we held with addr 0010 and wdata 00AA for 4 cycles; wb_write_en=0; mem_req low after ack.
REQ-022 The bench SHALL cover a LOAD timeout: no mem_ack, TIMEOUT_CYCLES=16 -> mem_req drops after 16 ACCESS cycles, mem_err=1 and sticky, wb_write_en=0.
REQ-023 The bench SHALL cover reset in the 2nd ACCESS cycle of a LOAD -> after the edge, mem_req=0, state IDLE, stall=0 for a NOP input, and no writeback.
REQ-024 The bench SHALL cover a LOAD immediately followed by an ADD -> the ADD appears on the writeback outputs exactly one edge after DONE, and the LOAD data is not overwritten early.
